// File: rtl/mux_arb_n_to_1_pkg.sv
// mux_arb_n_to_1_pkg: mode constants and width helper shared by the channel mux/arbiter.
package mux_arb_n_to_1_pkg;

    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mux_arb_n_to_1_rr_pick.sv
// rr_pick: combinational rotate-priority finder, first requester at or after ptr.
module rr_pick #(
    parameter int CH   = 3,
    parameter int SELW = 2
) (
    input  logic [CH-1:0]   req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [SELW-1:0] k;

    // ptr is always < CH, so one conditional subtract is a full modulo
    function automatic int wrap(input int a);
        return a >= CH ? a - CH : a;
    endfunction

    always_comb begin
        idx = '0;
        k   = '0;
        any = |req;
        for (int i = CH - 1; i >= 0; i--) begin
            k = SELW'(wrap(int'(ptr) + i));
            if (req[k]) idx = k;
        end
    end

endmodule

// File: rtl/mux_arb_n_to_1.sv
// mux_arb_n_to_1: CH-to-1 channel select (explicit or round-robin) into a registered
// valid/ready output stage.
module mux_arb_n_to_1
    import mux_arb_n_to_1_pkg::*;
#(
    parameter int size = 32,
    parameter int CH   = 3,
    parameter int SELW = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [CH*size-1:0] data_i,
    input  logic [CH-1:0]      valid_i,
    output logic [CH-1:0]      ready_o,
    input  logic               mode_i,
    input  logic [SELW-1:0]    select_i,
    output logic [size-1:0]    data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [SELW-1:0]    grant_o,
    output logic               sel_err_o
);

    if (CH < 2 || clog2(CH) > SELW) begin : g_bad_params
        $error("mux_arb_n_to_1: need CH >= 2 and 2**SELW >= CH");
    end

    logic [size-1:0]      chans [CH];
    logic [2**SELW-1:0]   valid_x;
    logic [SELW-1:0]      ptr, rr_idx, cand;
    logic                 rr_any, hit, load_en, sel_ok, take;

    for (genvar g = 0; g < CH; g++) begin : g_chan
        assign chans[g] = data_i[g*size +: size];
    end

    rr_pick #(.CH(CH), .SELW(SELW)) u_rr_pick (
        .req (valid_i),
        .ptr (ptr),
        .idx (rr_idx),
        .any (rr_any)
    );

    // valid_x widens valid_i so an out-of-range select indexes a defined 0
    always_comb begin
        valid_x = (2**SELW)'(valid_i);
        load_en = !valid_o || ready_i;
        sel_ok  = int'(select_i) < CH;
        cand    = mode_i == MODE_RR ? rr_idx : select_i;
        hit     = mode_i == MODE_RR ? rr_any : sel_ok && valid_x[select_i];
        take    = !rst_i && load_en && hit;
        ready_o = take ? CH'(1) << cand : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            grant_o   <= '0;
            sel_err_o <= 1'b0;
            ptr       <= '0;
        end else begin
            sel_err_o <= mode_i == MODE_EXPLICIT && !sel_ok && load_en;
            if (load_en) valid_o <= hit;
            if (take) begin
                data_o  <= chans[cand];
                grant_o <= cand;
                if (mode_i == MODE_RR) ptr <= cand == SELW'(CH - 1) ? '0 : cand + 1'b1;
            end
        end
    end

endmodule

// File: doc/mux_arb_n_to_1.md
Name: mux_arb_n_to_1

Overview:
Parametrised successor to the fixed 3-input datapath mux. Selects one of CH channels, either by explicit select (forwarding / writeback source select) or by round-robin arbitration over requesting channels (shared-resource access, e.g. memory port). The result is registered in a single output stage with valid/ready handshake on both sides. Sits between pipeline stages of the CPU datapath.

Parameters:
size, 32, data width per channel
CH, 3, number of input channels (2..16)
SELW, 2, select/grant width; must satisfy 2**SELW >= CH

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
data_i  input  CH*size  channel k occupies bits [k*size +: size]
valid_i  input  CH  per-channel request/valid
ready_o  output  CH  per-channel accept; one-hot or zero
mode_i  input  1  0 = explicit select, 1 = round-robin
select_i  input  SELW  channel index in explicit mode
data_o  output  size  registered selected data
valid_o  output  1  data_o holds an unconsumed item
ready_i  input  1  downstream accepts data_o
grant_o  output  SELW  index of channel that supplied data_o
sel_err_o  output  1  one-cycle pulse: explicit select out of range

Behaviour:
- Reset (rst_i=1 at a clock edge): data_o=0, valid_o=0, grant_o=0, sel_err_o=0, rr pointer=0. Applies mid-transfer; a held item is discarded. ready_o=0 while rst_i=1.
- load_en = !valid_o || ready_i (output stage empty or being drained this cycle).
- Candidate choice, combinational, per cycle:
  - mode_i=0: cand=select_i. hit = (select_i < CH) && valid_i[select_i].
  - mode_i=1: scan channels ptr, ptr+1, ... wrapping modulo CH. cand = first k with valid_i[k]=1. hit = |valid_i.
- ready_o[cand] = load_en && hit. All other ready_o bits are 0. ready_o never depends on ready_o of another channel; no combinational loop through valid_i beyond the scan.
- Transfer on channel cand when ready_o[cand] && valid_i[cand]. On that edge: data_o <= data_i[cand], grant_o <= cand, valid_o <= 1. Latency from input handshake to valid_o is 1 cycle.
- If load_en and !hit: valid_o <= 0. data_o and grant_o hold their last values.
- If !load_en (valid_o=1, ready_i=0): data_o, grant_o and valid_o hold. ready_o=0.
- Back-to-back: with ready_i held at 1, one item per cycle; simultaneous drain and load in the same cycle is legal.
- RR pointer: updates only on a transfer in mode_i=1, to (cand+1) mod CH; wrap from CH-1 gives 0. Explicit-mode transfers leave the pointer unchanged.
- Mode switch takes effect in the same cycle as mode_i changes. An item already held in the output stage is unaffected.
- sel_err_o: registered. Set to 1 for one cycle when mode_i=0, select_i >= CH, and load_en=1 at the edge. No transfer occurs. Otherwise sel_err_o is 0.
- Non-power-of-two CH: indices >= CH are never granted in either mode.

Decomposition:
- Shared package: MODE_EXPLICIT=1'b0, MODE_RR=1'b1 constants, and a log2-ceiling function for SELW checking.
- One sub-module: rr_pick (CH, SELW): combinational rotate-priority finder. Inputs: req vector, ptr. Outputs: idx, any. Reusable by other arbiters.
- Elaboration check: error if 2**SELW < CH or CH < 2.

Test Plan:
- Reset: drive valid_i=3'b111, assert rst_i for 2 cycles mid-stream -> valid_o=0, data_o=0, grant_o=0, ready_o=0. First RR grant after release is channel 0.
- Explicit select: mode_i=0, select_i=2, data ch2=32'hCAFE0002, valid_i=3'b100, ready_i=1 -> ready_o=3'b100. Next cycle data_o=32'hCAFE0002, grant_o=2, valid_o=1.
- Round-robin fairness: mode_i=1, valid_i=3'b111 constant, ready_i=1 for 6 cycles -> grant_o sequence 0,1,2,0,1,2. Then valid_i=3'b101 -> grants alternate 0,2.
- Backpressure: valid_o=1, ready_i=0 for 3 cycles with new inputs changing -> data_o and grant_o stable, ready_o=0. ready_i=1 -> same-cycle drain+load, no bubble, no lost item.
- Out-of-range select: mode_i=0, select_i=3, CH=3, output stage empty -> sel_err_o=1 for exactly one cycle, ready_o=0, valid_o=0.
- Mode switch mid-stream: RR pointer at 2, switch to mode_i=0 select_i=0 for 2 transfers, return to mode_i=1 with valid_i=3'b111 -> next grant is 2 (pointer preserved).
